// File: rtl/coax_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : coax_tx_serializer
//  Purpose  : Transmit serializer for the IBM 3270 coax link. Accepts 10-bit
//             words from the protocol layer and emits a bi-phase (Manchester)
//             framed message: 5-cell quiesce preamble, 3-cell code violation,
//             one or more 12-cell words (sync, data MSB first, even parity),
//             then a 2-cell end sequence.
//  Ports    : clk      - system clock, rising edge
//             reset_n  - asynchronous active-low reset
//             load     - word-load request, rising edge accepted
//             data     - 10-bit word, sampled on the accepting cycle
//             tx       - registered serial line level
//             active   - registered, high while a message is on the line
//  Revision : 1.0 - initial release
// ============================================================================
module coax_tx_serializer #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [9:0] data,
    output logic       tx,
    output logic       active
);

    localparam int                C_PH_W    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [C_PH_W-1:0] C_PH_LAST = C_PH_W'(CLOCKS_PER_BIT - 1);
    localparam logic [C_PH_W-1:0] C_PH_HALF = C_PH_W'(CLOCKS_PER_BIT / 2);
    localparam logic [C_PH_W-1:0] C_PH_ONE  = C_PH_W'(1);

    // Index of the final cell in each timed state
    localparam logic [3:0] C_QUI_LAST  = 4'd4;
    localparam logic [3:0] C_CV_LAST   = 4'd2;
    localparam logic [3:0] C_WORD_LAST = 4'd11;
    localparam logic [3:0] C_END_LAST  = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_CV      = 3'd2,
        S_WORD    = 3'd3,
        S_END     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [C_PH_W-1:0]   ph_q, ph_d;        // cycle within the current bit cell
    logic [3:0]          cell_q, cell_d;    // bit cell within the current state
    logic [9:0]          hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [11:0]         shift_q, shift_d;  // {sync, data[9:0], parity}, MSB on line
    logic                load_q;
    logic                tx_q, tx_d;
    logic                active_q, active_d;

    logic                accept;
    logic                cell_end;
    logic                word_entry;

    // Holding register only takes a word when empty; extra requests are dropped.
    assign accept   = load & ~load_q & ~hold_full_q;
    assign cell_end = (ph_q == C_PH_LAST);

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        cell_d      = cell_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        word_entry  = 1'b0;

        if (state_q != S_IDLE) begin
            ph_d = cell_end ? '0 : ph_q + C_PH_ONE;
            if (cell_end) begin
                cell_d = cell_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                ph_d   = '0;
                cell_d = '0;
                if (hold_full_q) begin
                    state_d = S_QUIESCE;
                end
            end
            S_QUIESCE: begin
                if (cell_end && cell_q == C_QUI_LAST) begin
                    state_d = S_CV;
                    cell_d  = '0;
                end
            end
            S_CV: begin
                if (cell_end && cell_q == C_CV_LAST) begin
                    state_d    = S_WORD;
                    cell_d     = '0;
                    word_entry = 1'b1;
                end
            end
            S_WORD: begin
                if (cell_end) begin
                    if (cell_q == C_WORD_LAST) begin
                        cell_d = '0;
                        // A queued word chains straight on with no gap.
                        if (hold_full_q) begin
                            word_entry = 1'b1;
                        end else begin
                            state_d = S_END;
                        end
                    end else begin
                        shift_d = {shift_q[10:0], 1'b0};
                    end
                end
            end
            S_END: begin
                if (cell_end && cell_q == C_END_LAST) begin
                    state_d = S_IDLE;
                    cell_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ph_d    = '0;
                cell_d  = '0;
            end
        endcase

        // Word entry requires a full holding register and accept requires an
        // empty one, so the two never coincide.
        if (word_entry) begin
            shift_d     = {1'b1, hold_q, ^hold_q};
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end
    end

    // Line level is derived from the next-state values so the registered tx
    // lines up with the state/counters in the same cycle.
    always_comb begin
        tx_d = 1'b0;
        case (state_d)
            S_IDLE:    tx_d = 1'b0;
            S_QUIESCE: tx_d = (ph_d < C_PH_HALF);
            S_CV:      tx_d = (cell_d == 4'd0) || ((cell_d == 4'd1) && (ph_d < C_PH_HALF));
            S_WORD:    tx_d = shift_d[11] ^ (ph_d >= C_PH_HALF);
            S_END:     tx_d = (cell_d == 4'd0) ? (ph_d >= C_PH_HALF) : 1'b1;
            default:   tx_d = 1'b0;
        endcase
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            cell_q      <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            load_q      <= 1'b0;
            tx_q        <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cell_q      <= cell_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            load_q      <= load;
            tx_q        <= tx_d;
            active_q    <= active_d;
        end
    end

    assign tx     = tx_q;
    assign active = active_q;

endmodule
`default_nettype wire

// File: tb/tb_coax_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coax_tx_serializer
//  Purpose  : Directed self-checking bench for coax_tx_serializer (CPB = 8).
//             Each bit cell is captured as an 8-sample byte: '1' = F0,
//             '0' = 0F; code violation cells are FF, F0, 00; end sequence
//             cells are 0F, FF.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_coax_tx_serializer;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic [9:0] data;
    logic       tx;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         msg_len;
    logic       tail_tx;
    logic       tail_active;

    coax_tx_serializer #(.CLOCKS_PER_BIT(CPB)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .data    (data),
        .tx      (tx),
        .active  (active)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic pulse(input logic [9:0] d, input int n);
        @(negedge clk);
        load = 1'b1;
        data = d;
        repeat (n) @(negedge clk);
        load = 1'b0;
        data = 10'h155;  // junk: must be ignored outside the accept cycle
    endtask

    // Waits for active, then records tx one byte per bit cell until active drops.
    task automatic capture_msg(input string name);
        int         n;
        logic [7:0] b;
        got_q.delete();
        msg_len = 0;
        n = 0;
        b = '0;
        while (active !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (active !== 1'b1) begin
            check({name, " start"}, 32'(active), 32'd1);
        end else begin
            while (active === 1'b1 && msg_len < 2000) begin
                b = {b[6:0], tx};
                msg_len++;
                if (msg_len % CPB == 0) got_q.push_back(b);
                @(negedge clk);
            end
        end
        tail_tx     = tx;
        tail_active = active;
    endtask

    task automatic exp_begin();
        exp_q.delete();
        repeat (5) exp_q.push_back(8'hF0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h00);
    endtask

    task automatic exp_word(input logic [11:0] bits);
        for (int i = 11; i >= 0; i--) exp_q.push_back(bits[i] ? 8'hF0 : 8'h0F);
    endtask

    task automatic exp_end();
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hFF);
    endtask

    task automatic compare_msg(input string name, input int len);
        check({name, " active_len"}, 32'(msg_len), 32'(len));
        check({name, " cells"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s cell%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({name, " tail_tx"}, 32'(tail_tx), 32'd0);
        check({name, " tail_active"}, 32'(tail_active), 32'd0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int hi;
        hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (active !== 1'b0 || tx !== 1'b0) hi++;
        end
        check({name, " quiet"}, 32'(hi), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        data    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 32'd0);
        check("rst active", 32'(active), 32'd0);
        reset_n = 1'b1;
        expect_quiet("post_rst", 10);

        // Single word 0x005: sync 1, 0000000101, parity 0
        fork
            capture_msg("single");
            pulse(10'h005, 4);
        join
        exp_begin(); exp_word(12'b1_0000000101_0); exp_end();
        compare_msg("single", 176);
        expect_quiet("single_after", 20);

        // Back-to-back: 0x005 then 0x3FF (sync 1, ten 1s, parity 0)
        fork
            capture_msg("b2b");
            begin
                pulse(10'h005, 2);
                repeat (98) @(negedge clk);
                pulse(10'h3FF, 2);
            end
        join
        exp_begin(); exp_word(12'b1_0000000101_0); exp_word(12'b1_1111111111_0); exp_end();
        compare_msg("b2b", 272);
        expect_quiet("b2b_after", 20);

        // Parity: 0x001 -> parity 1
        fork
            capture_msg("par1");
            pulse(10'h001, 2);
        join
        exp_begin(); exp_word(12'b1_0000000001_1); exp_end();
        compare_msg("par1", 176);
        expect_quiet("par1_after", 10);

        // Parity: 0x003 -> parity 0
        fork
            capture_msg("par0");
            pulse(10'h003, 2);
        join
        exp_begin(); exp_word(12'b1_0000000011_0); exp_end();
        compare_msg("par0", 176);
        expect_quiet("par0_after", 10);

        // Overrun: 0x0C3 sent, 0x201 queued, three 0x3F0 pulses dropped
        fork
            capture_msg("ovr");
            begin
                pulse(10'h0C3, 2);
                repeat (78) @(negedge clk);
                pulse(10'h201, 2);
                repeat (3) begin
                    repeat (3) @(negedge clk);
                    pulse(10'h3F0, 2);
                end
            end
        join
        exp_begin(); exp_word(12'b1_0011000011_0); exp_word(12'b1_1000000001_0); exp_end();
        compare_msg("ovr", 272);
        expect_quiet("ovr_after", 40);

        // Level load held past word entry: exactly one word (0x2AA, parity 1)
        fork
            capture_msg("level");
            pulse(10'h2AA, 100);
        join
        exp_begin(); exp_word(12'b1_1010101010_1); exp_end();
        compare_msg("level", 176);
        expect_quiet("level_after", 150);

        // Asynchronous reset mid-WORD
        pulse(10'h3FF, 2);
        repeat (100) @(negedge clk);
        check("pre_rst active", 32'(active), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst tx", 32'(tx), 32'd0);
        check("async_rst active", 32'(active), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        expect_quiet("rst_release", 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
